mma_wb_ctrl: RTL and testbench
==============================

# mma_wb_ctrl

Writeback-side controller for MMA instructions on the NICE path. It opens a transaction on `calc_start` and captures the MMA result, or a watchdog error if none arrives. It presents that result to the core with a `mma_wb_valid`/`mma_wb_ready` handshake. It produces the handshake that the retire/holdup tracker consumes, so the tracker's PENDING window ends exactly when this block's response is accepted.

## Interface
- `DATA_W`, 32: width of the result data.
- `RD_W`, 5: width of the destination register index.
- `TIMEOUT`, 1024: watchdog limit in cycles spent in BUSY. 0 disables the watchdog.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `calc_start` input 1: MMA instruction begins (single-cycle pulse).
- `calc_rd` input RD_W: destination register, sampled with `calc_start`.
- `calc_done` input 1: MMA datapath result valid (single-cycle pulse).
- `calc_result` input DATA_W: result, sampled with `calc_done`.
- `mma_wb_valid` output 1: writeback response valid.
- `mma_wb_ready` input 1: core accepts the response.
- `mma_wb_data` output DATA_W: response data.
- `mma_wb_rd` output RD_W: response destination register.
- `mma_wb_err` output 1: response is a watchdog timeout (data forced to 0).
- `busy` output 1: state is not IDLE.
- `err_clr` input 1: clears `proto_err`.
- `proto_err` output 1: sticky protocol-violation flag.

## Operation
- States: IDLE, BUSY, RESP. Encoding is 2 bits; the unused code returns to IDLE.
- **IDLE**
  - On `calc_start`: latch `calc_rd` into `mma_wb_rd`, clear the watchdog counter, go to BUSY.
- **BUSY**
  - The counter increments each cycle and saturates at TIMEOUT.
  - On `calc_done`: latch `calc_result` into `mma_wb_data`, set `mma_wb_err`=0, go to RESP.
  - Timeout: TIMEOUT≠0, no `calc_done`, and counter == TIMEOUT−1. Then set `mma_wb_data`=0 and `mma_wb_err`=1, go to RESP.
  - `calc_done` in the same cycle as the timeout: `calc_done` wins.
- **RESP**
  - `mma_wb_valid`=1.
  - Data, rd and err are held stable until the handshake (`mma_wb_valid && mma_wb_ready`). On handshake, go to IDLE.
- **Protocol errors.** `proto_err` is set by any of:
  - `calc_start` in BUSY or RESP; the start is ignored and the transaction in flight is unaffected.
  - `calc_done` in IDLE or RESP; the done is ignored and no data is overwritten.
  - `calc_start` and `calc_done` together in IDLE; the start is taken and the done is flagged.
- `err_clr` clears `proto_err`. When a set condition and `err_clr` occur in the same cycle, set wins.
- `calc_start` arriving in the RESP handshake cycle is flagged and dropped. The core must not issue until the tracker releases holdup.

## Timing
- Reset values: state IDLE, `mma_wb_valid`=0, `mma_wb_data`=0, `mma_wb_rd`=0, `mma_wb_err`=0, `busy`=0, `proto_err`=0, counter=0.
- All outputs are registered; there is no combinational path from any input to any output.
- `calc_start` at cycle N → `busy`=1 at N+1.
- `calc_done` at cycle M (in BUSY) → `mma_wb_valid`=1 at M+1.
- Handshake at cycle K → `mma_wb_valid`=0 and `busy`=0 at K+1. The earliest next accepted `calc_start` is at K+1.
- Watchdog: with `calc_start` at N and no done, `mma_wb_valid`=1 with `mma_wb_err`=1 at N+TIMEOUT+1.
- Counter width is $clog2(TIMEOUT+1). It is at least 1 bit when TIMEOUT=0.
- Asserting reset mid-transaction drops the transaction and takes all outputs to their reset values immediately; no response is produced.

## Structure
- Shared package `mma_wb_pkg`: state localparams (ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2) and the default TIMEOUT constant.
- One sub-module, `mma_wb_watchdog`, parameterised by TIMEOUT:
  - inputs: clk, rst_n, clr, en;
  - output: expire, a combinational pulse when count == TIMEOUT−1 and en is high; tied to 0 when TIMEOUT=0.
- The top level holds the FSM, the data/rd/err registers and the `proto_err` logic.

## Test plan
- Basic: `calc_start` (rd=5), `calc_done` 3 cycles later with result 0xDEADBEEF, ready held high → one-cycle valid with data 0xDEADBEEF, rd=5, err=0; `busy` drops the next cycle.
- Backpressure: ready low for 4 cycles after valid rises → valid and data stay stable for 4 cycles; exactly one handshake; IDLE one cycle after ready rises.
- Timeout: TIMEOUT=8, no `calc_done` → valid at start+9 with err=1, data=0; a `calc_done` arriving afterwards (in RESP) sets `proto_err` and does not change data.
- Done/timeout race: `calc_done` in the expiry cycle → err=0, result delivered.
- Overlap: second `calc_start` in BUSY → ignored, `proto_err`=1, first rd preserved; `err_clr` → `proto_err`=0 the next cycle.
- Reset mid-RESP: assert rst_n low while valid=1 → all outputs 0 asynchronously; after release, a new start/done completes normally.

Source files
------------

// File: rtl/mma_wb_pkg.sv
// Shared types and constants for the MMA writeback controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mma_wb_pkg;

   // Controller states; the fourth 2-bit code is unused and recovers to IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Default watchdog limit in BUSY cycles (0 disables the watchdog)
   localparam int unsigned MMA_WB_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/mma_wb_watchdog.sv
// Watchdog for an in-flight MMA: counts enabled cycles, saturating at TIMEOUT.
// Latency: expire is combinational from the count, high in the TIMEOUT-th enabled cycle.
// Backpressure: none; clr restarts the count, TIMEOUT=0 ties expire low.
module mma_wb_watchdog
   import mma_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = MMA_WB_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;

   // Cycle counter: restart on clr, otherwise count while enabled up to TIMEOUT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != CNT_W'(TIMEOUT))) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   generate
      if (TIMEOUT == 0) begin : g_disabled
         assign expire = 1'b0;
      end else begin : g_enabled
         assign expire = en && (cnt_q == CNT_W'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/mma_wb_ctrl.sv
// MMA writeback controller: captures a result (or watchdog error) per calc_start and returns it to the core.
// Latency: calc_done at M gives mma_wb_valid at M+1; timeout response at start+TIMEOUT+1; all outputs registered.
// Backpressure: response held stable in RESP until mma_wb_ready; new starts are flagged and dropped until then.
module mma_wb_ctrl
   import mma_wb_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RD_W    = 5,
   parameter int unsigned TIMEOUT = MMA_WB_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              calc_start,
   input  logic [RD_W-1:0]   calc_rd,
   input  logic              calc_done,
   input  logic [DATA_W-1:0] calc_result,
   output logic              mma_wb_valid,
   input  logic              mma_wb_ready,
   output logic [DATA_W-1:0] mma_wb_data,
   output logic [RD_W-1:0]   mma_wb_rd,
   output logic              mma_wb_err,
   output logic              busy,
   input  logic              err_clr,
   output logic              proto_err
);

   state_e            state_q;
   logic              valid_q;
   logic              busy_q;
   logic              err_q;
   logic              perr_q;
   logic              perr_d;
   logic [DATA_W-1:0] data_q;
   logic [RD_W-1:0]   rd_q;

   logic wd_clr;
   logic wd_en;
   logic wd_expire;
   logic perr_set;

   // Watchdog control and protocol-violation detection
   always_comb begin
      wd_clr   = (state_q == ST_IDLE) && calc_start;
      wd_en    = (state_q == ST_BUSY);
      // A start is only legal in IDLE, a done only in BUSY
      perr_set = (calc_start && (state_q != ST_IDLE)) ||
                 (calc_done  && (state_q != ST_BUSY));
      // Setting beats clearing so a violation in the clear cycle is not lost
      perr_d   = perr_set ? 1'b1 : (err_clr ? 1'b0 : perr_q);
   end

   mma_wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   // Transaction FSM with registered valid/busy and the response payload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
         rd_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (calc_start) begin
                  rd_q    <= calc_rd;
                  state_q <= ST_BUSY;
                  busy_q  <= 1'b1;
               end
            end
            ST_BUSY: begin
               // A real result arriving in the expiry cycle takes priority
               if (calc_done) begin
                  data_q  <= calc_result;
                  err_q   <= 1'b0;
                  state_q <= ST_RESP;
                  valid_q <= 1'b1;
               end else if (wd_expire) begin
                  data_q  <= '0;
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
                  valid_q <= 1'b1;
               end
            end
            ST_RESP: begin
               if (mma_wb_ready) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky protocol-error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign mma_wb_valid = valid_q;
   assign mma_wb_data  = data_q;
   assign mma_wb_rd    = rd_q;
   assign mma_wb_err   = err_q;
   assign busy         = busy_q;
   assign proto_err    = perr_q;

endmodule

// File: tb/tb_mma_wb_ctrl.sv
// Self-checking bench for mma_wb_ctrl with a short watchdog.
// Latency: directed scenarios check exact cycle timing; random phase checks every cycle.
// Backpressure: ready is driven low/high both deterministically and randomly.
module tb_mma_wb_ctrl;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned RD_W    = 5;
   localparam int unsigned TIMEOUT = 8;

   logic              clk;
   logic              rst_n;
   logic              calc_start;
   logic [RD_W-1:0]   calc_rd;
   logic              calc_done;
   logic [DATA_W-1:0] calc_result;
   logic              mma_wb_valid;
   logic              mma_wb_ready;
   logic [DATA_W-1:0] mma_wb_data;
   logic [RD_W-1:0]   mma_wb_rd;
   logic              mma_wb_err;
   logic              busy;
   logic              err_clr;
   logic              proto_err;

   int errors;
   int checks;
   int hs_cnt;

   mma_wb_ctrl #(
      .DATA_W  (DATA_W),
      .RD_W    (RD_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .calc_start   (calc_start),
      .calc_rd      (calc_rd),
      .calc_done    (calc_done),
      .calc_result  (calc_result),
      .mma_wb_valid (mma_wb_valid),
      .mma_wb_ready (mma_wb_ready),
      .mma_wb_data  (mma_wb_data),
      .mma_wb_rd    (mma_wb_rd),
      .mma_wb_err   (mma_wb_err),
      .busy         (busy),
      .err_clr      (err_clr),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshake counter, sampled on the falling edge
   always @(negedge clk) begin
      if (rst_n && mma_wb_valid && mma_wb_ready) hs_cnt++;
   end

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      calc_start   = 1'b0;
      calc_done    = 1'b0;
      err_clr      = 1'b0;
   endtask

   task automatic clear_perr();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      idle_inputs();
      calc_rd      = '0;
      calc_result  = '0;
      mma_wb_ready = 1'b1;
      #12;
      checks++;
      if ({mma_wb_valid, busy, mma_wb_err, proto_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got v/b/e/p=%b required 0000",
                  {mma_wb_valid, busy, mma_wb_err, proto_err});
      end
      checks++;
      if (mma_wb_data !== '0 || mma_wb_rd !== '0) begin
         errors++;
         $display("FAIL reset_payload: got data=%h rd=%0d required 0/0", mma_wb_data, mma_wb_rd);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int hs0;
      hs0 = hs_cnt;
      mma_wb_ready = 1'b1;
      calc_start = 1'b1; calc_rd = 5'd5;
      step();
      calc_start = 1'b0; calc_rd = 5'd0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL basic_busy: got %b required 1", busy);
      end
      step(); step();
      calc_done = 1'b1; calc_result = 32'hDEADBEEF;
      step();
      calc_done = 1'b0; calc_result = '0;
      checks++;
      if ({mma_wb_valid, mma_wb_err, mma_wb_rd, mma_wb_data} !== {1'b1, 1'b0, 5'd5, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL basic_resp: got v=%b e=%b rd=%0d data=%h required v=1 e=0 rd=5 data=deadbeef",
                  mma_wb_valid, mma_wb_err, mma_wb_rd, mma_wb_data);
      end
      step();
      checks++;
      if ({mma_wb_valid, busy} !== 2'b00 || hs_cnt != hs0 + 1) begin
         errors++;
         $display("FAIL basic_done: got v=%b busy=%b hs=%0d required v=0 busy=0 hs=1",
                  mma_wb_valid, busy, hs_cnt - hs0);
      end
   endtask

   task automatic test_backpressure();
      int hs0;
      hs0 = hs_cnt;
      mma_wb_ready = 1'b0;
      calc_start = 1'b1; calc_rd = 5'd17;
      step();
      calc_start = 1'b0;
      calc_done = 1'b1; calc_result = 32'hA5A5_0F0F;
      step();
      calc_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (!(mma_wb_valid === 1'b1 && mma_wb_data === 32'hA5A5_0F0F && mma_wb_rd === 5'd17)) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b data=%h rd=%0d required v=1 data=a5a50f0f rd=17",
                     i, mma_wb_valid, mma_wb_data, mma_wb_rd);
         end
         step();
      end
      mma_wb_ready = 1'b1;
      checks++;
      if (mma_wb_valid !== 1'b1 || hs_cnt != hs0) begin
         errors++;
         $display("FAIL bp_still_valid: got v=%b hs=%0d required v=1 hs=0", mma_wb_valid, hs_cnt - hs0);
      end
      step();
      checks++;
      if ({mma_wb_valid, busy} !== 2'b00 || hs_cnt != hs0 + 1) begin
         errors++;
         $display("FAIL bp_release: got v=%b busy=%b hs=%0d required v=0 busy=0 hs=1",
                  mma_wb_valid, busy, hs_cnt - hs0);
      end
   endtask

   task automatic test_timeout();
      mma_wb_ready = 1'b0;
      calc_start = 1'b1; calc_rd = 5'd9;
      step();
      calc_start = 1'b0;
      for (int i = 0; i < int'(TIMEOUT) - 1; i++) step();
      checks++;
      if (mma_wb_valid !== 1'b0) begin
         errors++; $display("FAIL to_early: got v=%b at start+%0d required 0", mma_wb_valid, TIMEOUT);
      end
      step();
      checks++;
      if ({mma_wb_valid, mma_wb_err, mma_wb_data, mma_wb_rd} !== {1'b1, 1'b1, 32'h0, 5'd9}) begin
         errors++;
         $display("FAIL to_resp: got v=%b e=%b data=%h rd=%0d required v=1 e=1 data=0 rd=9",
                  mma_wb_valid, mma_wb_err, mma_wb_data, mma_wb_rd);
      end
      calc_done = 1'b1; calc_result = 32'h1234_5678;
      step();
      calc_done = 1'b0;
      checks++;
      if ({proto_err, mma_wb_valid, mma_wb_err, mma_wb_data} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL to_late_done: got perr=%b v=%b e=%b data=%h required perr=1 v=1 e=1 data=0",
                  proto_err, mma_wb_valid, mma_wb_err, mma_wb_data);
      end
      mma_wb_ready = 1'b1;
      step();
      clear_perr();
   endtask

   task automatic test_race();
      mma_wb_ready = 1'b1;
      calc_start = 1'b1; calc_rd = 5'd30;
      step();
      calc_start = 1'b0;
      for (int i = 0; i < int'(TIMEOUT) - 1; i++) step();
      calc_done = 1'b1; calc_result = 32'hCAFE_F00D;
      step();
      calc_done = 1'b0;
      checks++;
      if ({mma_wb_valid, mma_wb_err, mma_wb_data, proto_err} !== {1'b1, 1'b0, 32'hCAFE_F00D, 1'b0}) begin
         errors++;
         $display("FAIL race: got v=%b e=%b data=%h perr=%b required v=1 e=0 data=cafef00d perr=0",
                  mma_wb_valid, mma_wb_err, mma_wb_data, proto_err);
      end
      step();
   endtask

   task automatic test_overlap();
      mma_wb_ready = 1'b1;
      calc_start = 1'b1; calc_rd = 5'd3;
      step();
      calc_rd = 5'd9;
      step();
      calc_start = 1'b0;
      checks++;
      if ({proto_err, busy, mma_wb_valid} !== 3'b110) begin
         errors++;
         $display("FAIL ovl_flag: got perr=%b busy=%b v=%b required 1 1 0", proto_err, busy, mma_wb_valid);
      end
      calc_done = 1'b1; calc_result = 32'h0000_0042;
      err_clr = 1'b1;
      step();
      calc_done = 1'b0; err_clr = 1'b0;
      checks++;
      if ({mma_wb_valid, mma_wb_rd, mma_wb_data, proto_err} !== {1'b1, 5'd3, 32'h42, 1'b0}) begin
         errors++;
         $display("FAIL ovl_resp: got v=%b rd=%0d data=%h perr=%b required v=1 rd=3 data=42 perr=0",
                  mma_wb_valid, mma_wb_rd, mma_wb_data, proto_err);
      end
      // A start in the handshake cycle is dropped and flagged
      calc_start = 1'b1; calc_rd = 5'd11;
      step();
      calc_start = 1'b0;
      checks++;
      if ({busy, proto_err, mma_wb_rd} !== {1'b0, 1'b1, 5'd3}) begin
         errors++;
         $display("FAIL ovl_hs_start: got busy=%b perr=%b rd=%0d required busy=0 perr=1 rd=3",
                  busy, proto_err, mma_wb_rd);
      end
      // Set beats clear when both land together
      calc_done = 1'b1; err_clr = 1'b1;
      step();
      calc_done = 1'b0; err_clr = 1'b0;
      checks++;
      if (proto_err !== 1'b1) begin
         errors++; $display("FAIL ovl_set_wins: got perr=%b required 1", proto_err);
      end
      clear_perr();
      checks++;
      if (proto_err !== 1'b0) begin
         errors++; $display("FAIL ovl_clr: got perr=%b required 0", proto_err);
      end
   endtask

   task automatic test_reset_mid();
      mma_wb_ready = 1'b0;
      calc_start = 1'b1; calc_rd = 5'd21;
      step();
      calc_start = 1'b0;
      calc_done = 1'b1; calc_result = 32'h7777_1111;
      step();
      calc_done = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mma_wb_valid, busy, mma_wb_err, proto_err, mma_wb_rd, mma_wb_data} !== '0) begin
         errors++;
         $display("FAIL rst_mid: got v=%b busy=%b rd=%0d data=%h required all 0",
                  mma_wb_valid, busy, mma_wb_rd, mma_wb_data);
      end
      #1 rst_n = 1'b1;
      mma_wb_ready = 1'b1;
      step();
      calc_start = 1'b1; calc_rd = 5'd6;
      step();
      calc_start = 1'b0;
      calc_done = 1'b1; calc_result = 32'h0BAD_F00D;
      step();
      calc_done = 1'b0;
      checks++;
      if ({mma_wb_valid, mma_wb_err, mma_wb_rd, mma_wb_data} !== {1'b1, 1'b0, 5'd6, 32'h0BAD_F00D}) begin
         errors++;
         $display("FAIL rst_recover: got v=%b e=%b rd=%0d data=%h required v=1 e=0 rd=6 data=0badf00d",
                  mma_wb_valid, mma_wb_err, mma_wb_rd, mma_wb_data);
      end
      step();
   endtask

   // Random traffic against a transaction-level model
   task automatic test_random();
      bit              m_open;      // a transaction is in flight (BUSY or awaiting acceptance)
      bit              m_have;      // its response exists and is being offered
      int              m_age;       // cycles spent waiting for a result
      bit              m_err;
      bit              m_perr;
      logic [RD_W-1:0] m_rd;
      logic [31:0]     m_data;
      bit              viol;
      logic [40:0]     exp_v;
      logic [40:0]     got_v;

      rst_n = 1'b0;
      idle_inputs();
      #3 rst_n = 1'b1;
      step();
      m_open = 0; m_have = 0; m_age = 0; m_err = 0; m_perr = 0; m_rd = '0; m_data = '0;

      for (int cyc = 0; cyc < 1500; cyc++) begin
         calc_start   = ($urandom_range(0, 3) == 0);
         calc_rd      = RD_W'($urandom);
         calc_done    = ($urandom_range(0, 4) == 0);
         calc_result  = $urandom;
         mma_wb_ready = ($urandom_range(0, 1) == 0);
         err_clr      = ($urandom_range(0, 7) == 0);

         viol = (calc_start && m_open) || (calc_done && !(m_open && !m_have));
         if (!m_open) begin
            if (calc_start) begin
               m_open = 1; m_rd = calc_rd; m_age = 0;
            end
         end else if (!m_have) begin
            m_age++;
            if (calc_done) begin
               m_have = 1; m_data = calc_result; m_err = 0;
            end else if (m_age == int'(TIMEOUT)) begin
               m_have = 1; m_data = '0; m_err = 1;
            end
         end else if (mma_wb_ready) begin
            m_open = 0; m_have = 0;
         end
         if (viol) m_perr = 1;
         else if (err_clr) m_perr = 0;

         step();
         exp_v = {m_have, m_open, m_err, m_perr, m_rd, m_data};
         got_v = {mma_wb_valid, busy, mma_wb_err, proto_err, mma_wb_rd, mma_wb_data};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL rand_cyc%0d: got v/b/e/p=%b rd=%0d data=%h required v/b/e/p=%b rd=%0d data=%h",
                     cyc, got_v[40:37], got_v[36:32], got_v[31:0], exp_v[40:37], exp_v[36:32], exp_v[31:0]);
         end
      end
      idle_inputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      hs_cnt = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_race();
      test_overlap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
